redmule_mx_exp_packer: RTL and testbench
========================================

Name: redmule_mx_exp_packer

Overview:
Downstream consumer of the MX output stage's shared-exponent stream (one 8-bit exponent per encoded 32-element block). It packs consecutive exponents into DATAW_ALIGN-bit memory words, with byte strobes, for the Z-exponent store streamer. It tracks a per-tile exponent count, flushes the final partial word, and pulses done when the tile's exponents are fully emitted.

Parameters:
DATAW_ALIGN, 512, output word width in bits; must be a multiple of EXP_W.
EXP_W, 8, shared-exponent width in bits.
CNT_W, 16, width of the exponent count.
EPW (derived), DATAW_ALIGN/EXP_W = 64, exponents per output word.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear; returns block to IDLE
start_i  in  1  tile start; sampled only in IDLE
num_exps_i  in  CNT_W  exponents in the tile; latched on start_i
exp_valid_i  in  1  exponent stream valid
exp_ready_o  out  1  exponent stream ready
exp_data_i  in  EXP_W  exponent (low byte of the MX output stage's exponent stream)
out_valid_o  out  1  packed word valid
out_ready_i  in  1  packed word ready
out_data_o  out  DATAW_ALIGN  packed exponents
out_strb_o  out  DATAW_ALIGN/8  byte strobes
out_last_o  out  1  final word of tile (qualified by out_valid_o)
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle tile-complete pulse

Behaviour:
- Reset (async, rst_ni low): all outputs 0; state IDLE; buffer, strobes and counters 0. clear_i applies the same values synchronously and drops any partial word without emitting it.
- State IDLE:
  - exp_ready_o=0.
  - start_i with num_exps_i!=0: latch remain=num_exps_i, slot=0, buffer/strb=0, go to FILL.
  - start_i with num_exps_i==0: go to DONE; no word is emitted.
- State FILL:
  - exp_ready_o=1, out_valid_o=0.
  - On handshake: write exp_data_i to bits [EXP_W*slot +: EXP_W], set strb bit slot, slot++, remain--.
  - If the handshake fills slot EPW-1, or remain becomes 0: go to EMIT on the next cycle.
- State EMIT:
  - exp_ready_o=0, out_valid_o=1.
  - out_last_o = (remain==0).
  - data, strb and last stay stable until the handshake.
  - On out handshake: if remain==0 go to DONE; else clear buffer/strb, slot=0, go to FILL.
- State DONE: done_o=1 for exactly one cycle; go to IDLE the next cycle.
- Byte order: the first exponent of a word is byte 0 (LSB). Unfilled bytes are 0 with strb 0.
- Latency: the exponent that completes a word is accepted in cycle N; out_valid_o is high from cycle N+1.
- Throughput: 1 exponent per cycle, plus one bubble cycle per emitted word (single buffer; the EMIT state blocks input).
- Events ignored:
  - exp_valid_i in IDLE, EMIT or DONE: not accepted.
  - start_i outside IDLE: ignored.
- Count width: remain is CNT_W bits and never underflows; FILL exits when remain reaches 0.
- clear_i has priority over start_i and over all handshakes in the same cycle.

Test Plan:
- start, num_exps_i=64, exponents 0x00..0x3F back-to-back → one word: byte k=k, strb all-ones, out_last_o=1; done_o pulses 1 cycle after the out handshake.
- num_exps_i=70, exponents 0x80+k → word0 full with strb all-ones and last=0; word1 bytes0..5=0x80+64..0x80+69, remaining bytes 0, strb=0x3F, last=1; exp_ready_o is low for exactly 1 cycle between the words.
- num_exps_i=3, out_ready_i held low 10 cycles in EMIT → out_data_o/out_strb_o(=0x7) stable; exp_ready_o=0 throughout; word completes on out_ready_i=1.
- start_i with num_exps_i=0 → no out_valid_o; done_o pulses one cycle later; busy_o high 1 cycle.
- num_exps_i=64, clear_i after 20 exponents → IDLE next cycle, no word emitted; a new start with 2 exponents → strb=0x3, bytes 2..63 zero.
- rst_ni asserted mid-EMIT → all outputs 0 immediately; block stays in IDLE after release.

Source files
------------

// File: rtl/redmule_mx_exp_packer_if.sv
// Handshake bundle for redmule_mx_exp_packer.
//   exp_valid / exp_ready / exp_data : incoming shared-exponent stream
//   out_valid / out_ready / out_data / out_strb / out_last : packed word stream
// slave  : the packer (consumes exponents, produces packed words)
// master : the environment (produces exponents, consumes packed words)
interface redmule_mx_exp_packer_if #(
   parameter int unsigned DATAW_ALIGN = 512,
   parameter int unsigned EXP_W       = 8
);
   logic                     exp_valid;
   logic                     exp_ready;
   logic [EXP_W-1:0]         exp_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATAW_ALIGN-1:0]   out_data;
   logic [DATAW_ALIGN/8-1:0] out_strb;
   logic                     out_last;

   modport master (
      output exp_valid, exp_data, out_ready,
      input  exp_ready, out_valid, out_data, out_strb, out_last
   );

   modport slave (
      input  exp_valid, exp_data, out_ready,
      output exp_ready, out_valid, out_data, out_strb, out_last
   );
endinterface

// File: rtl/redmule_mx_exp_packer.sv
// Packs the MX output stage's shared exponents (one per 32-element block)
// into DATAW_ALIGN-bit words with byte strobes for the Z-exponent store
// streamer. A tile of num_exps_i exponents is counted down; the final partial
// word is flushed with out_last set, then done_o pulses for one cycle.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear back to IDLE, drops any partial word
//   start_i         tile start (IDLE only), num_exps_i latched with it
//   num_exps_i      exponents in the tile
//   bus (slave)     exponent input stream and packed word output stream
//   busy_o          high in any state except IDLE
//   done_o          one-cycle tile-complete pulse
//
// State | meaning
// IDLE  | waiting for start_i
// FILL  | accepting exponents into the word buffer
// EMIT  | presenting the packed word, input blocked
// DONE  | tile complete, done_o high for one cycle
module redmule_mx_exp_packer #(
   parameter int unsigned DATAW_ALIGN = 512,
   parameter int unsigned EXP_W       = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic                      start_i,
   input  logic [CNT_W-1:0]          num_exps_i,
   redmule_mx_exp_packer_if.slave    bus,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int unsigned EPW    = DATAW_ALIGN / EXP_W;
   localparam int unsigned SLOT_W = (EPW > 1) ? $clog2(EPW) : 1;
   localparam int unsigned STRB_W = DATAW_ALIGN / 8;
   localparam int unsigned SB     = EXP_W / 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] EMIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]             state_q;
   logic [DATAW_ALIGN-1:0] buf_q;
   logic [STRB_W-1:0]      strb_q;
   logic [SLOT_W-1:0]      slot_q;
   logic [CNT_W-1:0]       remain_q;

   logic exp_hs;
   logic out_hs;

   assign exp_hs = (state_q == FILL) && bus.exp_valid;
   assign out_hs = (state_q == EMIT) && bus.out_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         strb_q   <= '0;
         slot_q   <= '0;
         remain_q <= '0;
      end else if (clear_i) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         strb_q   <= '0;
         slot_q   <= '0;
         remain_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  remain_q <= num_exps_i;
                  slot_q   <= '0;
                  buf_q    <= '0;
                  strb_q   <= '0;
                  state_q  <= (num_exps_i != '0) ? FILL : DONE;
               end
            end
            FILL: begin
               if (exp_hs) begin
                  buf_q[EXP_W*slot_q +: EXP_W] <= bus.exp_data;
                  strb_q[SB*slot_q +: SB]      <= '1;
                  slot_q                       <= slot_q + SLOT_W'(1);
                  remain_q                     <= remain_q - CNT_W'(1);
                  // remain is never 0 in FILL, so reaching 1 here means the
                  // tile's last exponent was just taken.
                  if (slot_q == SLOT_W'(EPW - 1) || remain_q == CNT_W'(1)) begin
                     state_q <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (out_hs) begin
                  if (remain_q == '0) begin
                     state_q <= DONE;
                  end else begin
                     buf_q   <= '0;
                     strb_q  <= '0;
                     slot_q  <= '0;
                     state_q <= FILL;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.exp_ready = (state_q == FILL);
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_data  = buf_q;
   assign bus.out_strb  = strb_q;
   assign bus.out_last  = (state_q == EMIT) && (remain_q == '0);
   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_redmule_mx_exp_packer.sv
module tb_redmule_mx_exp_packer;

   localparam int unsigned DW    = 512;
   localparam int unsigned EW    = 8;
   localparam int unsigned CW    = 16;
   localparam int unsigned SW    = DW / 8;

   logic          clk_i;
   logic          rst_ni;
   logic          clear_i;
   logic          start_i;
   logic [CW-1:0] num_exps_i;
   logic          busy_o;
   logic          done_o;

   int errors;
   int checks;

   redmule_mx_exp_packer_if #(.DATAW_ALIGN(DW), .EXP_W(EW)) pk_if ();

   redmule_mx_exp_packer #(.DATAW_ALIGN(DW), .EXP_W(EW), .CNT_W(CW)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .start_i    (start_i),
      .num_exps_i (num_exps_i),
      .bus        (pk_if),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Offers one exponent; returns how many cycles it waited for exp_ready.
   task automatic push(input logic [EW-1:0] d, output int waits);
      waits = 0;
      pk_if.exp_valid = 1'b1;
      pk_if.exp_data  = d;
      while (pk_if.exp_ready !== 1'b1 && waits < 50) begin
         @(negedge clk_i);
         waits++;
      end
      if (waits >= 50) chk("push_timeout", 1, 0);
      @(negedge clk_i);
      pk_if.exp_valid = 1'b0;
   endtask

   task automatic do_start(input logic [CW-1:0] n);
      start_i    = 1'b1;
      num_exps_i = n;
      @(negedge clk_i);
      start_i    = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] exp_word;
      logic [SW-1:0] exp_strb;
      int            w;

      errors = 0;
      checks = 0;
      rst_ni = 1'b0;
      clear_i = 1'b0;
      start_i = 1'b0;
      num_exps_i = '0;
      pk_if.exp_valid = 1'b0;
      pk_if.exp_data  = '0;
      pk_if.out_ready = 1'b1;

      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_exp_ready", pk_if.exp_ready, 0);
      chk("rst_out_valid", pk_if.out_valid, 0);
      chk("rst_data", pk_if.out_data, 0);
      chk("rst_strb", pk_if.out_strb, 0);
      chk("rst_last", pk_if.out_last, 0);

      // One full word of 64 exponents 0x00..0x3F
      do_start(16'd64);
      chk("t1_busy", busy_o, 1);
      chk("t1_ready", pk_if.exp_ready, 1);
      for (int k = 0; k < 64; k++) push(8'(k), w);
      exp_word = '0;
      for (int k = 0; k < 64; k++) exp_word[k*8 +: 8] = 8'(k);
      chk("t1_valid", pk_if.out_valid, 1);
      chk("t1_data", pk_if.out_data, exp_word);
      chk("t1_strb", pk_if.out_strb, {SW{1'b1}});
      chk("t1_last", pk_if.out_last, 1);
      chk("t1_ready_emit", pk_if.exp_ready, 0);
      @(negedge clk_i);
      chk("t1_done", done_o, 1);
      chk("t1_valid_after", pk_if.out_valid, 0);
      @(negedge clk_i);
      chk("t1_done_once", done_o, 0);
      chk("t1_idle", busy_o, 0);

      // 70 exponents: full word then 6-exponent tail
      do_start(16'd70);
      for (int k = 0; k < 64; k++) push(8'(8'h80 + k), w);
      exp_word = '0;
      for (int k = 0; k < 64; k++) exp_word[k*8 +: 8] = 8'(8'h80 + k);
      chk("t2_w0_data", pk_if.out_data, exp_word);
      chk("t2_w0_strb", pk_if.out_strb, {SW{1'b1}});
      chk("t2_w0_last", pk_if.out_last, 0);
      chk("t2_w0_valid", pk_if.out_valid, 1);
      push(8'h80 + 8'd64, w);
      chk("t2_bubble", w, 1);
      for (int k = 65; k < 70; k++) begin
         push(8'(8'h80 + k), w);
         chk("t2_no_bubble", w, 0);
      end
      exp_word = '0;
      for (int k = 0; k < 6; k++) exp_word[k*8 +: 8] = 8'(8'hC0 + k);
      chk("t2_w1_data", pk_if.out_data, exp_word);
      chk("t2_w1_strb", pk_if.out_strb, 64'h3F);
      chk("t2_w1_last", pk_if.out_last, 1);
      @(negedge clk_i);
      chk("t2_done", done_o, 1);
      @(negedge clk_i);

      // 3 exponents with 10 cycles of back-pressure in EMIT
      pk_if.out_ready = 1'b0;
      do_start(16'd3);
      push(8'h11, w);
      push(8'h22, w);
      push(8'h33, w);
      pk_if.exp_valid = 1'b1;
      pk_if.exp_data  = 8'hFF;
      start_i = 1'b1;
      num_exps_i = 16'd5;
      for (int c = 0; c < 10; c++) begin
         chk("t3_hold_data", pk_if.out_data, 512'h33_22_11);
         chk("t3_hold_strb", pk_if.out_strb, 64'h7);
         chk("t3_hold_ready", pk_if.exp_ready, 0);
         chk("t3_hold_valid", pk_if.out_valid, 1);
         @(negedge clk_i);
      end
      start_i = 1'b0;
      pk_if.exp_valid = 1'b0;
      chk("t3_last", pk_if.out_last, 1);
      pk_if.out_ready = 1'b1;
      @(negedge clk_i);
      chk("t3_done", done_o, 1);
      @(negedge clk_i);
      chk("t3_idle", busy_o, 0);

      // Zero-length tile
      do_start(16'd0);
      chk("t4_done", done_o, 1);
      chk("t4_busy", busy_o, 1);
      chk("t4_valid", pk_if.out_valid, 0);
      @(negedge clk_i);
      chk("t4_done_once", done_o, 0);
      chk("t4_busy_once", busy_o, 0);
      chk("t4_valid2", pk_if.out_valid, 0);

      // clear mid-fill, then a fresh 2-exponent tile
      do_start(16'd64);
      for (int k = 0; k < 20; k++) push(8'(8'h40 + k), w);
      clear_i = 1'b1;
      pk_if.exp_valid = 1'b1;
      pk_if.exp_data  = 8'h5A;
      @(negedge clk_i);
      clear_i = 1'b0;
      pk_if.exp_valid = 1'b0;
      chk("t5_busy", busy_o, 0);
      chk("t5_ready", pk_if.exp_ready, 0);
      chk("t5_strb", pk_if.out_strb, 0);
      chk("t5_data", pk_if.out_data, 0);
      repeat (3) begin
         @(negedge clk_i);
         chk("t5_no_word", pk_if.out_valid, 0);
      end
      do_start(16'd2);
      push(8'hA1, w);
      push(8'hA2, w);
      exp_strb = 64'h3;
      chk("t5_new_strb", pk_if.out_strb, exp_strb);
      chk("t5_new_data", pk_if.out_data, 512'hA2A1);
      chk("t5_new_last", pk_if.out_last, 1);
      @(negedge clk_i);
      chk("t5_new_done", done_o, 1);
      @(negedge clk_i);

      // async reset while a word is held in EMIT
      pk_if.out_ready = 1'b0;
      do_start(16'd3);
      push(8'h01, w);
      push(8'h02, w);
      push(8'h03, w);
      chk("t6_emit", pk_if.out_valid, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_valid", pk_if.out_valid, 0);
      chk("t6_data", pk_if.out_data, 0);
      chk("t6_strb", pk_if.out_strb, 0);
      chk("t6_last", pk_if.out_last, 0);
      chk("t6_busy", busy_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      pk_if.out_ready = 1'b1;
      pk_if.exp_valid = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("t6_stay_idle", busy_o, 0);
      chk("t6_stay_ready", pk_if.exp_ready, 0);
      chk("t6_stay_valid", pk_if.out_valid, 0);
      pk_if.exp_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
